// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full-adder cell plus a registered carry, stepped LSB
// first over WIDTH bits. Results are registered and held until the next add completes.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             c;
  logic [CW-1:0]    cnt;

  logic fa_sum;
  logic fa_carry;

  // The single full-adder cell, always fed by the current LSBs and stored carry.
  assign fa_sum   = op_a[0] ^ op_b[0] ^ c;
  assign fa_carry = (op_a[0] & op_b[0]) | (op_a[0] & c) | (op_b[0] & c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            c     <= carry_in;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          c    <= fa_carry;
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          acc  <= {fa_sum, acc[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          // Final bit: publish the whole word directly, bypassing acc.
          if (cnt == LAST) begin
            sum       <= {fa_sum, acc[WIDTH-1:1]};
            carry_out <= fa_carry;
            state     <= DONE;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Scoreboard bench: stimulus pushes expected {carry_out,sum}; monitors pop on done.
// Covers directed WIDTH=8 vectors and an exhaustive WIDTH=4 sweep.
module tb_serial_adder_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, ci8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, ci4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, co4;
  logic [3:0] sum4;

  serial_adder_fsm #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .carry_in(ci8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
  );

  serial_adder_fsm #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .carry_in(ci4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] val;
    int         acc_cyc;
  } exp8_t;

  exp8_t      q8[$];
  logic [4:0] q4[$];
  int         last4 = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // WIDTH=8 monitor: result and accept-to-done latency
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done8_unexpected: got sum=%0h co=%0h expected no done", sum8, co8);
      end else begin
        exp8_t e;
        e = q8.pop_front();
        $display("txn w8: sum=%0h co=%0b expect=%0h lat=%0d", sum8, co8, e.val, cyc - e.acc_cyc);
        check("result8", {23'd0, co8, sum8}, {23'd0, e.val});
        check("latency8", cyc - e.acc_cyc, 8);
      end
    end
  end

  // WIDTH=4 monitor: result and done-to-done spacing
  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done4_unexpected: got sum=%0h co=%0h expected no done", sum4, co4);
      end else begin
        logic [4:0] e4;
        e4 = q4.pop_front();
        $display("txn w4: sum=%0h co=%0b expect=%0h", sum4, co4, e4);
        check("result4", {27'd0, co4, sum4}, {27'd0, e4});
        if (last4 >= 0) check("gap4", cyc - last4, 6);
        last4 = cyc;
      end
    end
  end

  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [8:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (busy8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("idle_wait8");
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    q8.push_back('{val: exp, acc_cyc: cyc});
  endtask

  task automatic drain8();
    int n;
    n = 0;
    while (q8.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("drain8");
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy8}, 0);
    check("rst_done", {31'd0, done8}, 0);
    check("rst_sum", {24'd0, sum8}, 0);
    check("rst_co", {31'd0, co8}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1-3: basic, wrap-around, carry isolation
    add8(8'h5A, 8'h3C, 1'b0, 9'h096);
    drain8();
    add8(8'hFF, 8'h01, 1'b0, 9'h100);
    drain8();
    add8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    drain8();
    add8(8'h00, 8'h00, 1'b0, 9'h000);
    drain8();

    // 4: start during RUN and DONE is ignored
    add8(8'h10, 8'h20, 1'b0, 9'h030);
    repeat (3) @(negedge clk);
    check("busy_run", {31'd0, busy8}, 1);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("done_wait4");
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_after", {31'd0, busy8}, 0);
    check("sum_held", {24'd0, sum8}, 32'h30);
    check("q8_empty", q8.size(), 0);

    // 5: asynchronous abort mid-run
    add8(8'h7F, 8'h01, 1'b0, 9'h080);
    void'(q8.pop_back());
    repeat (4) @(negedge clk);
    check("busy_pre_rst", {31'd0, busy8}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy8}, 0);
    check("abort_done", {31'd0, done8}, 0);
    check("abort_sum", {24'd0, sum8}, 0);
    check("abort_co", {31'd0, co8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", {24'd0, sum8}, 0);
    add8(8'h01, 8'h02, 1'b0, 9'h003);
    drain8();

    // 6: WIDTH=4 exhaustive with start held high
    @(negedge clk);
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          n = 0;
          while (busy4 && n < 20) begin
            @(negedge clk);
            n++;
          end
          if (n >= 20) fail_now("idle_wait4");
          a4 = 4'(ia); b4 = 4'(ib); ci4 = 1'(ic); start4 = 1'b1;
          q4.push_back(5'(ia) + 5'(ib) + 5'(ic));
          @(posedge clk);
          #1;
          @(negedge clk);
        end
      end
    end
    start4 = 1'b0;
    n = 0;
    while (q4.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail_now("drain4");
    check("q4_empty", q4.size(), 0);
    check("busy4_end", {31'd0, busy4}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
